// File: rtl/image_led_seq_if.sv
// Control/status bundle between the top-level controller and the LED image sequencer.
// The master drives requests and the dwell time; the slave returns the datapath strobes and progress.
interface image_led_seq_if #(
  parameter int NUM_BYTES = 784,
  parameter int DWELL_W   = 24
);
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  logic               start;
  logic               pause;
  logic               abort;
  logic [DWELL_W-1:0] dwell;
  logic               load;
  logic               push;
  logic               busy;
  logic               done;
  logic [IDX_W-1:0]   byte_idx;

  modport master (
    output start, pause, abort, dwell,
    input  load, push, busy, done, byte_idx
  );

  modport slave (
    input  start, pause, abort, dwell,
    output load, push, busy, done, byte_idx
  );
endinterface

// File: rtl/image_led_seq.sv
// Paces the LED image datapath: one reload pulse, then one push per dwell interval
// until every byte of the image has been shown. Supports pause and abort.
module image_led_seq #(
  parameter int NUM_BYTES = 784,
  parameter int DWELL_W   = 24
) (
  input  logic          clk,
  input  logic          rst,
  image_led_seq_if.slave bus
);
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_BYTES - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, SHOW, DONE} state_t;

  state_t             state, state_nxt;
  logic [DWELL_W-1:0] timer, timer_nxt;
  logic [DWELL_W-1:0] dwell_q, dwell_nxt;
  logic [IDX_W-1:0]   idx_q, idx_nxt;
  logic               load_q, load_nxt;
  logic               push_q, push_nxt;
  logic               done_q, done_nxt;
  logic               busy_q, busy_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      dwell_q <= DWELL_ONE;
      idx_q   <= '0;
      load_q  <= 1'b0;
      push_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      dwell_q <= dwell_nxt;
      idx_q   <= idx_nxt;
      load_q  <= load_nxt;
      push_q  <= push_nxt;
      done_q  <= done_nxt;
      busy_q  <= busy_nxt;
    end
  end

  // Outputs are computed for the state being entered so they register alongside it;
  // abort always wins over a coincident expiry so no stray push leaks out.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    dwell_nxt = dwell_q;
    idx_nxt   = idx_q;
    load_nxt  = 1'b0;
    push_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nxt = LOAD;
          dwell_nxt = (bus.dwell == '0) ? DWELL_ONE : bus.dwell;
          load_nxt  = 1'b1;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = SHOW;
          timer_nxt = '0;
          idx_nxt   = '0;
        end
      end
      SHOW: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (!bus.pause) begin
          if (timer == dwell_q - DWELL_ONE) begin
            timer_nxt = '0;
            push_nxt  = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_nxt   = '0;
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end else begin
              idx_nxt = idx_q + IDX_W'(1);
            end
          end else begin
            timer_nxt = timer + DWELL_ONE;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.load     = load_q;
  assign bus.push     = push_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.byte_idx = idx_q;
endmodule

// File: tb/tb_image_led_seq.sv
// Directed and randomized checks of image_led_seq against a push-schedule model
// that predicts absolute push cycles from the start cycle, dwell and pause history.
module tb_image_led_seq;
  localparam int NB = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;

  image_led_seq_if #(.NUM_BYTES(NB), .DWELL_W(DW)) bus ();

  image_led_seq #(.NUM_BYTES(NB), .DWELL_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference schedule: absolute cycle numbers of the load pulse and the next push
  bit act = 0;
  int loadAt = 0, pushAt = 0, left = 0, idx = 0, dq = 1;
  bit eLoad = 0, ePush = 0, eDone = 0, eBusy = 0;

  int pushLog[$];
  bit logPushes = 0;

  task automatic modelEdge(input bit r, input bit s, input bit p, input bit a, input int d);
    int prev;
    prev  = cyc;
    cyc   = cyc + 1;
    ePush = 0;
    eDone = 0;
    if (r) begin
      act = 0;
      idx = 0;
    end else if (!act) begin
      if (s && !a) begin
        act    = 1;
        dq     = (d == 0) ? 1 : d;
        loadAt = cyc;
        pushAt = cyc + 1 + dq;
        left   = NB;
      end
    end else if (left == 0 || a) begin
      act = 0;
    end else begin
      if (prev > loadAt && p) pushAt++;
      if (cyc == loadAt + 1) idx = 0;
      if (cyc == pushAt) begin
        ePush  = 1;
        idx    = (idx + 1) % NB;
        left   = left - 1;
        eDone  = (left == 0);
        pushAt = pushAt + dq;
      end
    end
    eLoad = act && (cyc == loadAt);
    eBusy = act;
  endtask

  task automatic checkOutput();
    vectors++;
    assert (bus.load === eLoad) else begin
      miscompares++;
      $error("[TB] FAIL load cyc=%0d observed=%b expected=%b", cyc, bus.load, eLoad);
    end
    assert (bus.push === ePush) else begin
      miscompares++;
      $error("[TB] FAIL push cyc=%0d observed=%b expected=%b", cyc, bus.push, ePush);
    end
    assert (bus.done === eDone) else begin
      miscompares++;
      $error("[TB] FAIL done cyc=%0d observed=%b expected=%b", cyc, bus.done, eDone);
    end
    assert (bus.busy === eBusy) else begin
      miscompares++;
      $error("[TB] FAIL busy cyc=%0d observed=%b expected=%b", cyc, bus.busy, eBusy);
    end
    assert (bus.byte_idx === 2'(idx)) else begin
      miscompares++;
      $error("[TB] FAIL byte_idx cyc=%0d observed=%0d expected=%0d", cyc, bus.byte_idx, idx);
    end
    if (logPushes && bus.push === 1'b1) pushLog.push_back(cyc);
  endtask

  // One clock cycle: inputs held for cycle cyc, then the edge, then check cycle cyc+1
  task automatic applyStimulus(input bit r, input bit s, input bit p, input bit a, input int d);
    @(negedge clk);
    rst       = r;
    bus.start = s;
    bus.pause = p;
    bus.abort = a;
    bus.dwell = DW'(d);
    @(posedge clk);
    modelEdge(r, s, p, a, d);
    #1;
    checkOutput();
  endtask

  task automatic idleCycles(input int n, input int d);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, d);
  endtask

  initial begin
    int tStart;
    int expPush[4];
    rst = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.abort = 1'b0;
    bus.dwell = '0;

    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 3);
    idleCycles(3, 3);

    $display("[TB] basic pass, dwell 3");
    logPushes = 1;
    tStart = cyc;
    applyStimulus(0, 1, 0, 0, 3);
    idleCycles(18, 3);
    logPushes = 0;
    expPush[0] = tStart + 5;
    expPush[1] = tStart + 8;
    expPush[2] = tStart + 11;
    expPush[3] = tStart + 14;
    vectors++;
    assert (pushLog.size() == 4) else begin
      miscompares++;
      $error("[TB] FAIL push_count observed=%0d expected=4", pushLog.size());
    end
    for (int i = 0; i < 4 && i < pushLog.size(); i++) begin
      vectors++;
      assert (pushLog[i] == expPush[i]) else begin
        miscompares++;
        $error("[TB] FAIL push_cycle[%0d] observed=%0d expected=%0d", i, pushLog[i], expPush[i]);
      end
    end

    $display("[TB] dwell 0 and dwell 1");
    applyStimulus(0, 1, 0, 0, 0);
    idleCycles(8, 0);
    applyStimulus(0, 1, 0, 0, 1);
    idleCycles(8, 1);

    $display("[TB] pause before first expiry");
    applyStimulus(0, 1, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 3);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 3);
    idleCycles(20, 3);

    $display("[TB] abort on second expiry, then restart");
    applyStimulus(0, 1, 0, 0, 3);
    idleCycles(6, 3);
    applyStimulus(0, 0, 0, 1, 3);
    idleCycles(2, 3);
    applyStimulus(0, 1, 0, 0, 2);
    idleCycles(14, 2);

    $display("[TB] start while busy, start with abort in idle");
    applyStimulus(0, 1, 1, 1, 3);
    applyStimulus(0, 1, 0, 0, 2);
    applyStimulus(0, 1, 0, 0, 4);
    applyStimulus(0, 1, 1, 0, 4);
    idleCycles(3, 4);
    applyStimulus(0, 1, 0, 0, 4);
    idleCycles(12, 4);

    $display("[TB] reset mid-pass, then full pass");
    applyStimulus(0, 1, 0, 0, 2);
    idleCycles(5, 2);
    applyStimulus(1, 0, 0, 0, 2);
    idleCycles(2, 2);
    applyStimulus(0, 1, 0, 0, 2);
    idleCycles(14, 2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 299) == 0,
                    $urandom_range(0, 5) == 0,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 49) == 0,
                    int'($urandom_range(0, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
